// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage MIPS core: load-use, ID-resolved branch and
// HI/LO / mult-div stalls, the mult/div busy FSM and a saturating stall counter.
`timescale 1ns/1ps
module hazard_ctrl #(
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 32,
  parameter int CNT_W       = 6,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [4:0]             IF_ID_rs,
  input  logic [4:0]             IF_ID_rt,
  input  logic                   ID_uses_rt,
  input  logic                   ID_branch,
  input  logic                   ID_branch_taken,
  input  logic                   ID_hilo_read,
  input  logic                   ID_muldiv,
  input  logic                   ID_EX_mem_read,
  input  logic                   ID_EX_reg_write,
  input  logic [4:0]             ID_EX_rd,
  input  logic                   EX_MEM_mem_read,
  input  logic [4:0]             EX_MEM_rd,
  input  logic                   EX_muldiv_start,
  input  logic                   EX_muldiv_op,
  output logic                   pc_write,
  output logic                   IF_ID_write,
  output logic                   ID_EX_flush,
  output logic                   IF_ID_flush,
  output logic                   muldiv_busy,
  output logic                   muldiv_done,
  output logic [STALL_CNT_W-1:0] stall_count
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} md_state_t;

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  md_state_t        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  logic load_use, br_stall, hilo_stall, md_stall, stall;

  // r0 is hard-wired to zero, so a write to it can never create a dependency.
  function automatic logic src_match(input logic [4:0] x, input logic [4:0] rs,
                                     input logic [4:0] rt, input logic uses_rt);
    return (x != 5'd0) && ((x == rs) || (uses_rt && (x == rt)));
  endfunction

  function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
    return (&v) ? v : v + STALL_CNT_W'(1);
  endfunction

  function automatic logic [CNT_W-1:0] md_load(input logic op);
    return op ? DIV_LOAD : MULT_LOAD;
  endfunction

  always_comb begin
    load_use   = ID_EX_mem_read && src_match(ID_EX_rd, IF_ID_rs, IF_ID_rt, ID_uses_rt);
    br_stall   = ID_branch &&
                 ((ID_EX_reg_write && src_match(ID_EX_rd, IF_ID_rs, IF_ID_rt, ID_uses_rt)) ||
                  (EX_MEM_mem_read && src_match(EX_MEM_rd, IF_ID_rs, IF_ID_rt, ID_uses_rt)));
    hilo_stall = ID_hilo_read && (EX_muldiv_start || (state != IDLE));
    md_stall   = ID_muldiv && (EX_muldiv_start || (state == BUSY));
    stall      = load_use || br_stall || hilo_stall || md_stall;
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // FSM next state; a start while BUSY is unreachable because md_stall holds it in ID
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: begin
        if (EX_muldiv_start) begin
          state_nxt = BUSY;
          cnt_nxt   = md_load(EX_muldiv_op);
        end
      end
      BUSY: begin
        if (cnt == '0) state_nxt = DONE;
        else           cnt_nxt   = cnt - CNT_W'(1);
      end
      DONE: begin
        if (EX_muldiv_start) begin
          state_nxt = BUSY;
          cnt_nxt   = md_load(EX_muldiv_op);
        end else begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs; while reset is held the pipeline runs free and nothing is flagged
  always_comb begin
    pc_write    = 1'b1;
    IF_ID_write = 1'b1;
    ID_EX_flush = 1'b0;
    IF_ID_flush = 1'b0;
    muldiv_busy = 1'b0;
    muldiv_done = 1'b0;
    if (rst_n) begin
      muldiv_busy = (state == BUSY);
      muldiv_done = (state == DONE);
      if (stall) begin
        pc_write    = 1'b0;
        IF_ID_write = 1'b0;
        ID_EX_flush = 1'b1;
      end else begin
        IF_ID_flush = ID_branch && ID_branch_taken;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     stall_count <= '0;
    else if (stall) stall_count <= sat_inc(stall_count);
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the 5-stage MIPS core. It sits beside the forwarding unit and sequences the pipeline registers. It detects the hazards that forwarding cannot cover: load-use, branch operands resolved in ID, and HI/LO and multi-cycle mult/div conflicts. For each it drives PC/IF_ID write-enables, the ID_EX bubble and the IF_ID flush. It also owns the mult/div busy FSM and a saturating stall-cycle counter.

## Interface
Parameters:
- MULT_CYCLES, 4, mult/multu latency in cycles (≥1)
- DIV_CYCLES, 32, div/divu latency in cycles (≥1)
- CNT_W, 6, mult/div countdown width (must hold max(MULT_CYCLES,DIV_CYCLES)-1)
- STALL_CNT_W, 16, stall counter width

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- IF_ID_rs, IF_ID_rt  in  5 each  source registers of instruction in ID
- ID_uses_rt  in  1  ID instruction reads rt as a source
- ID_branch  in  1  ID holds beq/bne (compared in ID)
- ID_branch_taken  in  1  ID comparator result, valid only when no stall
- ID_hilo_read  in  1  ID holds mfhi/mflo
- ID_muldiv  in  1  ID holds mult/multu/div/divu
- ID_EX_mem_read, ID_EX_reg_write  in  1 each
- ID_EX_rd  in  5  final destination of EX instruction (rt for loads)
- EX_MEM_mem_read  in  1
- EX_MEM_rd  in  5
- EX_muldiv_start  in  1  mult/div in EX this cycle
- EX_muldiv_op  in  1  0=mult, 1=div
- pc_write  out  1  PC enable
- IF_ID_write  out  1  IF_ID enable
- ID_EX_flush  out  1  insert bubble into ID_EX
- IF_ID_flush  out  1  squash IF_ID (taken branch)
- muldiv_busy  out  1  FSM in BUSY
- muldiv_done  out  1  one-cycle HI/LO write strobe
- stall_count  out  STALL_CNT_W  saturating count of stall cycles

## Operation
Register r0 never causes a hazard. "match(x)" means x≠0 and (x==IF_ID_rs or (ID_uses_rt and x==IF_ID_rt)).
- load_use = ID_EX_mem_read and match(ID_EX_rd).
- br_stall = ID_branch and ((ID_EX_reg_write and match(ID_EX_rd)) or (EX_MEM_mem_read and match(EX_MEM_rd))).
- hilo_stall = ID_hilo_read and (EX_muldiv_start or state≠IDLE).
- md_stall = ID_muldiv and (EX_muldiv_start or state==BUSY).
- stall = OR of the four terms above.
- stall=1: pc_write=0, IF_ID_write=0, ID_EX_flush=1, IF_ID_flush=0.
- stall=0: pc_write=1, IF_ID_write=1, ID_EX_flush=0, IF_ID_flush=ID_branch and ID_branch_taken.
- Stall has priority over a taken branch; the branch re-resolves after the stall.

Mult/div FSM (states IDLE, BUSY, DONE):
- IDLE: EX_muldiv_start loads cnt=(op ? DIV_CYCLES : MULT_CYCLES)-1 and moves to BUSY.
- BUSY: cnt==0 moves to DONE, else cnt decrements. EX_muldiv_start is ignored here; it cannot occur legally because md_stall prevents it.
- DONE: muldiv_done=1. EX_muldiv_start reloads cnt and moves to BUSY, else the FSM returns to IDLE.
- muldiv_busy = (state==BUSY).

stall_count increments on every clock edge where stall=1. It saturates at all-ones and never wraps.

Reset (rst_n low, asynchronous):
- state=IDLE, cnt=0, stall_count=0.
- While rst_n is low, outputs are forced to pc_write=1, IF_ID_write=1, ID_EX_flush=0, IF_ID_flush=0, muldiv_busy=0, muldiv_done=0, regardless of other inputs.
- Reset during BUSY abandons the operation; no muldiv_done is issued.

## Timing
- Stall/flush outputs are combinational from the current inputs and state, with zero latency.
- FSM and counter update on the rising edge.
- Start sampled in cycle 0: BUSY during cycles 1..N, DONE in cycle N+1 (N=MULT_CYCLES or DIV_CYCLES). Default mult gives done in cycle 5; default div gives done in cycle 33.
- hilo_stall holds from cycle 0 through cycle N+1. mfhi/mflo leaves ID in cycle N+2.
- A back-to-back muldiv in ID is released in DONE (cycle N+1) and reaches EX in cycle N+2.
- Load-use stall lasts exactly 1 cycle.
- Branch-on-ALU-result stall: 1 cycle. Branch-on-load stall: 2 cycles (EX match, then MEM match).

## Test plan
- Load-use: lw $t0 in EX (ID_EX_mem_read=1, rd=8), ID rs=8 → cycle 0 shows pc_write=0, IF_ID_write=0, ID_EX_flush=1. The next cycle returns to normal. stall_count goes from 0 to 1.
- r0 immunity: the same as above with rd=0 → no stall. An ID_uses_rt=0 rt-only match → no stall.
- Branch after load: lw rd=9, ID beq rs=9, branch_taken=1 → 2 stall cycles with IF_ID_flush=0. The third cycle shows IF_ID_flush=1 and pc_write=1.
- mult then mflo: EX_muldiv_start=1, op=0, ID_hilo_read=1 → stall in cycles 0..5, muldiv_busy in cycles 1..4, muldiv_done in cycle 5 only, release in cycle 6. stall_count=6.
- div then mult back-to-back: start op=1, ID_muldiv=1 → md_stall in cycles 0..32 and DONE in cycle 33. A start in cycle 34 returns to BUSY and gives done in cycle 39.
- Reset mid-div: assert rst_n=0 in cycle 10 of BUSY → immediate IDLE and muldiv_busy=0, with no muldiv_done and stall_count=0. Separately, force 2^16+3 stall cycles → stall_count holds 0xFFFF.
